// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared widths, NOOP word and state type for the CPU memory responder
// Contents:
//   ADDR_W_DEF   default word-address width (DEPTH = 1 << ADDR_W)
//   DATA_W_DEF   default word width
//   NOOP_WORD    value presented on the read ports while the CPU is held
//   mem_state_e  responder state: CLEAR=0, LOAD=1, RUN=2
package cpu_mem_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 32;

    localparam logic [31:0] NOOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_bank_2r1w.sv
// rtl/mem_bank_2r1w.sv - DEPTH x DATA_W storage with two registered read ports and one write port
// Ports:
//   clk, resetn        clock, asynchronous active-low reset of the read registers only
//   flush              1 = both read registers load NOOP_WORD instead of array data
//   we, waddr, wdata   write port, written at the rising edge
//   re_a, raddr_a      read port A enable/address; rdata_a valid after the edge
//   re_b, raddr_b      read port B enable/address; rdata_b valid after the edge
//   rdata_a, rdata_b   registered read data, held while the port is not enabled
module mem_bank_2r1w
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Array has no reset; it is zeroed by the owner through the write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Write-first: a same-edge write to the address being read is forwarded.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_a <= DATA_W'(NOOP_WORD);
            rdata_b <= DATA_W'(NOOP_WORD);
        end else if (flush) begin
            rdata_a <= DATA_W'(NOOP_WORD);
            rdata_b <= DATA_W'(NOOP_WORD);
        end else begin
            if (re_a) begin
                rdata_a <= (we && (waddr == raddr_a)) ? wdata : mem[raddr_a];
            end
            if (re_b) begin
                rdata_b <= (we && (waddr == raddr_b)) ? wdata : mem[raddr_b];
            end
        end
    end

endmodule

// File: rtl/cpu_mem_responder.sv
// rtl/cpu_mem_responder.sv - unified instruction/data store with clear, boot loader and CPU ports
// Ports:
//   clk, resetn                          clock, asynchronous active-low reset
//   read_mem_ir, mem_radrs_ir            instruction read enable/address
//   instruction_fetch                    instruction read data (latency 1)
//   read_mem_str, mem_radrs_LD           LOAD read enable/address
//   mem_store_data                       LOAD read data (latency 1)
//   write_mem, mem_wadrs, mem_wdata      STORE write port
//   load_valid, load_ready               loader handshake
//   load_addr, load_data, load_last      loader beat contents
//   cpu_hold                             1 = CPU must stay held
//   load_err                             sticky: loader beat offered outside LOAD
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BOOT_LOAD = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              read_mem_ir,
    input  logic [ADDR_W-1:0] mem_radrs_ir,
    output logic [DATA_W-1:0] instruction_fetch,
    input  logic              read_mem_str,
    input  logic [ADDR_W-1:0] mem_radrs_LD,
    output logic [DATA_W-1:0] mem_store_data,
    input  logic              write_mem,
    input  logic [ADDR_W-1:0] mem_wadrs,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              cpu_hold,
    output logic              load_err
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    mem_state_e        state_q;
    logic [ADDR_W-1:0] clr_addr;

    logic              bank_we;
    logic [ADDR_W-1:0] bank_waddr;
    logic [DATA_W-1:0] bank_wdata;
    logic              run_mode;
    logic              beat_accept;

    assign run_mode    = (state_q == ST_RUN);
    assign beat_accept = load_valid && load_ready;

    // cpu_hold and load_ready are registered and change on the same edge as the state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_CLEAR;
            clr_addr   <= '0;
            cpu_hold   <= 1'b1;
            load_ready <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            if (load_valid && (state_q != ST_LOAD)) begin
                load_err <= 1'b1;
            end
            case (state_q)
                ST_CLEAR: begin
                    clr_addr <= clr_addr + ADDR_W'(1);
                    if (clr_addr == ADDR_MAX) begin
                        if (BOOT_LOAD != 0) begin
                            state_q    <= ST_LOAD;
                            load_ready <= 1'b1;
                        end else begin
                            state_q  <= ST_RUN;
                            cpu_hold <= 1'b0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (beat_accept && load_last) begin
                        state_q    <= ST_RUN;
                        load_ready <= 1'b0;
                        cpu_hold   <= 1'b0;
                    end
                end
                ST_RUN: begin
                end
                default: begin
                    // Unused encoding: restart with a full clear.
                    state_q    <= ST_CLEAR;
                    clr_addr   <= '0;
                    cpu_hold   <= 1'b1;
                    load_ready <= 1'b0;
                end
            endcase
        end
    end

    // Single array write port shared by the clear sweep, the loader and CPU stores.
    always_comb begin
        bank_we    = 1'b0;
        bank_waddr = clr_addr;
        bank_wdata = '0;
        case (state_q)
            ST_CLEAR: begin
                bank_we    = 1'b1;
                bank_waddr = clr_addr;
                bank_wdata = '0;
            end
            ST_LOAD: begin
                bank_we    = beat_accept;
                bank_waddr = load_addr;
                bank_wdata = load_data;
            end
            ST_RUN: begin
                bank_we    = write_mem;
                bank_waddr = mem_wadrs;
                bank_wdata = mem_wdata;
            end
            default: begin
                bank_we = 1'b0;
            end
        endcase
    end

    mem_bank_2r1w #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bank (
        .clk     (clk),
        .resetn  (resetn),
        .flush   (!run_mode),
        .we      (bank_we),
        .waddr   (bank_waddr),
        .wdata   (bank_wdata),
        .re_a    (read_mem_ir),
        .raddr_a (mem_radrs_ir),
        .rdata_a (instruction_fetch),
        .re_b    (read_mem_str),
        .raddr_b (mem_radrs_LD),
        .rdata_b (mem_store_data)
    );

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb/tb_cpu_mem_responder.sv - self-checking bench for cpu_mem_responder (direct and random traffic)
module tb_cpu_mem_responder;

    logic        clk = 1'b0;
    logic        resetn;
    logic        read_mem_ir;
    logic [10:0] mem_radrs_ir;
    logic        read_mem_str;
    logic [10:0] mem_radrs_LD;
    logic        write_mem;
    logic [10:0] mem_wadrs;
    logic [31:0] mem_wdata;
    logic        load_valid;
    logic [10:0] load_addr;
    logic [31:0] load_data;
    logic        load_last;

    logic [31:0] if0, sd0, if1, sd1;
    logic        lr0, hold0, err0, lr1, hold1, err1;

    int passed = 0;
    int total  = 0;

    // Behavioural view of dut1's storage and its two read-data outputs.
    logic [31:0] model [0:2047];
    logic [31:0] exp_ir, exp_sd;

    always #5 clk = ~clk;

    cpu_mem_responder #(.ADDR_W(11), .DATA_W(32), .BOOT_LOAD(0)) dut0 (
        .clk(clk), .resetn(resetn),
        .read_mem_ir(read_mem_ir), .mem_radrs_ir(mem_radrs_ir), .instruction_fetch(if0),
        .read_mem_str(read_mem_str), .mem_radrs_LD(mem_radrs_LD), .mem_store_data(sd0),
        .write_mem(write_mem), .mem_wadrs(mem_wadrs), .mem_wdata(mem_wdata),
        .load_valid(load_valid), .load_ready(lr0), .load_addr(load_addr),
        .load_data(load_data), .load_last(load_last),
        .cpu_hold(hold0), .load_err(err0)
    );

    cpu_mem_responder #(.ADDR_W(11), .DATA_W(32), .BOOT_LOAD(1)) dut1 (
        .clk(clk), .resetn(resetn),
        .read_mem_ir(read_mem_ir), .mem_radrs_ir(mem_radrs_ir), .instruction_fetch(if1),
        .read_mem_str(read_mem_str), .mem_radrs_LD(mem_radrs_LD), .mem_store_data(sd1),
        .write_mem(write_mem), .mem_wadrs(mem_wadrs), .mem_wdata(mem_wdata),
        .load_valid(load_valid), .load_ready(lr1), .load_addr(load_addr),
        .load_data(load_data), .load_last(load_last),
        .cpu_hold(hold1), .load_err(err1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        read_mem_ir  = 1'b0;
        mem_radrs_ir = '0;
        read_mem_str = 1'b0;
        mem_radrs_LD = '0;
        write_mem    = 1'b0;
        mem_wadrs    = '0;
        mem_wdata    = '0;
        load_valid   = 1'b0;
        load_addr    = '0;
        load_data    = '0;
        load_last    = 1'b0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2048; i++) model[i] = 32'h0;
        exp_ir = 32'h0;
        exp_sd = 32'h0;
    endtask

    task automatic test_reset();
        idle();
        resetn = 1'b0;
        repeat (3) tick();
        total++; if ({hold0, hold1} !== 2'b11) $display("FAIL reset_hold got=%b exp=11", {hold0, hold1}); else passed++;
        total++; if ({lr0, lr1, err0, err1} !== 4'b0000) $display("FAIL reset_ready_err got=%b exp=0000", {lr0, lr1, err0, err1}); else passed++;
        total++; if ({if0, sd0, if1, sd1} !== 128'h0) $display("FAIL reset_rdata got=%h exp=0", {if0, sd0, if1, sd1}); else passed++;
        model_clear();
        resetn = 1'b1;
    endtask

    // BOOT_LOAD=0 releases the CPU after exactly 2048 clear cycles.
    task automatic test_clear_release();
        int n;
        n = 0;
        while (hold0 === 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        total++; if (n != 2048) $display("FAIL clear_release_cycles got=%0d exp=2048", n); else passed++;
        total++; if (hold1 !== 1'b1 || lr1 !== 1'b1) $display("FAIL boot_enter_load hold=%b ready=%b exp=1/1", hold1, lr1); else passed++;
        total++; if (lr0 !== 1'b0) $display("FAIL run_ready got=%b exp=0", lr0); else passed++;
        read_mem_ir = 1'b1; mem_radrs_ir = 11'h7FF;
        read_mem_str = 1'b1; mem_radrs_LD = 11'h7FF;
        tick();
        idle();
        total++; if (if0 !== 32'h0 || sd0 !== 32'h0) $display("FAIL clear_read_7ff got=%h/%h exp=0", if0, sd0); else passed++;
    endtask

    task automatic test_loader();
        load_valid = 1'b1; load_addr = 11'h000; load_data = 32'hE000_0005; load_last = 1'b0;
        tick();
        model[0] = 32'hE000_0005;
        total++; if (hold1 !== 1'b1 || lr1 !== 1'b1) $display("FAIL loader_mid hold=%b ready=%b exp=1/1", hold1, lr1); else passed++;
        load_addr = 11'h001; load_data = 32'h8000_0000; load_last = 1'b1;
        tick();
        model[1] = 32'h8000_0000;
        idle();
        total++; if (hold1 !== 1'b0 || lr1 !== 1'b0) $display("FAIL loader_release hold=%b ready=%b exp=0/0", hold1, lr1); else passed++;
        total++; if (err1 !== 1'b0) $display("FAIL loader_no_err got=%b exp=0", err1); else passed++;
        total++; if (err0 !== 1'b1) $display("FAIL run_beat_err got=%b exp=1", err0); else passed++;
        read_mem_ir = 1'b1; mem_radrs_ir = 11'h000;
        read_mem_str = 1'b1; mem_radrs_LD = 11'h001;
        tick();
        idle();
        exp_ir = model[0];
        exp_sd = model[1];
        total++; if (if1 !== 32'hE000_0005) $display("FAIL loader_fetch got=%h exp=e0000005", if1); else passed++;
        total++; if (sd1 !== 32'h8000_0000) $display("FAIL loader_ld got=%h exp=80000000", sd1); else passed++;
        total++; if (if0 !== 32'h0) $display("FAIL run_beat_dropped got=%h exp=0", if0); else passed++;
    endtask

    task automatic test_store_load();
        write_mem = 1'b1; mem_wadrs = 11'h123; mem_wdata = 32'hDEAD_BEEF;
        tick();
        model[11'h123] = 32'hDEAD_BEEF;
        idle();
        read_mem_str = 1'b1; mem_radrs_LD = 11'h123;
        tick();
        idle();
        exp_sd = model[11'h123];
        total++; if (sd1 !== 32'hDEAD_BEEF) $display("FAIL store_load got=%h exp=deadbeef", sd1); else passed++;
        total++; if (if1 !== exp_ir) $display("FAIL ir_hold got=%h exp=%h", if1, exp_ir); else passed++;
        tick();
        total++; if (sd1 !== 32'hDEAD_BEEF) $display("FAIL ld_hold got=%h exp=deadbeef", sd1); else passed++;
    endtask

    task automatic test_collision();
        write_mem = 1'b1; mem_wadrs = 11'h010; mem_wdata = 32'h0000_00AA;
        read_mem_ir = 1'b1; mem_radrs_ir = 11'h010;
        read_mem_str = 1'b1; mem_radrs_LD = 11'h010;
        tick();
        idle();
        model[11'h010] = 32'h0000_00AA;
        exp_ir = 32'h0000_00AA;
        exp_sd = 32'h0000_00AA;
        total++; if (if1 !== 32'h0000_00AA) $display("FAIL collide_ir got=%h exp=000000aa", if1); else passed++;
        total++; if (sd1 !== 32'h0000_00AA) $display("FAIL collide_ld got=%h exp=000000aa", sd1); else passed++;
    endtask

    task automatic test_load_err();
        load_valid = 1'b1; load_addr = 11'h000; load_data = 32'hFFFF_FFFF; load_last = 1'b1;
        tick();
        idle();
        total++; if (err1 !== 1'b1) $display("FAIL load_err_set got=%b exp=1", err1); else passed++;
        read_mem_ir = 1'b1; mem_radrs_ir = 11'h000;
        tick();
        idle();
        exp_ir = model[0];
        total++; if (if1 !== 32'hE000_0005) $display("FAIL load_err_word got=%h exp=e0000005", if1); else passed++;
        repeat (5) tick();
        total++; if (err1 !== 1'b1 || hold1 !== 1'b0) $display("FAIL load_err_sticky err=%b hold=%b exp=1/0", err1, hold1); else passed++;
    endtask

    task automatic test_random();
        logic [10:0] ra, rb, wa;
        logic [31:0] wd;
        logic        re_a, re_b, we;
        int          bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            re_a = 1'($urandom_range(0, 1));
            re_b = 1'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            ra   = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(0, 15));
            rb   = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(0, 15));
            wa   = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(0, 15));
            wd   = $urandom;
            read_mem_ir = re_a; mem_radrs_ir = ra;
            read_mem_str = re_b; mem_radrs_LD = rb;
            write_mem = we; mem_wadrs = wa; mem_wdata = wd;
            if (re_a) exp_ir = (we && wa == ra) ? wd : model[ra];
            if (re_b) exp_sd = (we && wa == rb) ? wd : model[rb];
            if (we) model[wa] = wd;
            tick();
            total++;
            if (if1 !== exp_ir) begin
                if (bad < 10) $display("FAIL rand_ir it=%0d got=%h exp=%h", i, if1, exp_ir);
                bad++;
            end else passed++;
            total++;
            if (sd1 !== exp_sd) begin
                if (bad < 10) $display("FAIL rand_ld it=%0d got=%h exp=%h", i, sd1, exp_sd);
                bad++;
            end else passed++;
        end
        idle();
    endtask

    task automatic test_reset_mid_load();
        int n;
        logic [31:0] d;
        resetn = 1'b0;
        #2;
        total++; if (hold1 !== 1'b1 || lr1 !== 1'b0 || err1 !== 1'b0) $display("FAIL rst_run hold=%b ready=%b err=%b exp=1/0/0", hold1, lr1, err1); else passed++;
        total++; if (if1 !== 32'h0 || sd1 !== 32'h0) $display("FAIL rst_run_rdata got=%h/%h exp=0", if1, sd1); else passed++;
        tick();
        resetn = 1'b1;
        model_clear();
        n = 0;
        while (lr1 !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        total++; if (n != 2048) $display("FAIL reclear_cycles got=%0d exp=2048", n); else passed++;
        for (int b = 0; b < 3; b++) begin
            d = $urandom | 32'h1;
            load_valid = 1'b1; load_addr = 11'(32 + b); load_data = d; load_last = 1'b0;
            tick();
        end
        idle();
        tick();
        resetn = 1'b0;
        #2;
        total++; if (hold1 !== 1'b1 || lr1 !== 1'b0) $display("FAIL rst_load hold=%b ready=%b exp=1/0", hold1, lr1); else passed++;
        tick();
        resetn = 1'b1;
        n = 0;
        while (lr1 !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        total++; if (n != 2048) $display("FAIL reload_cycles got=%0d exp=2048", n); else passed++;
        load_valid = 1'b1; load_addr = 11'h030; load_data = 32'h1234_5678; load_last = 1'b1;
        tick();
        idle();
        total++; if (hold1 !== 1'b0) $display("FAIL rst_rerun_hold got=%b exp=0", hold1); else passed++;
        for (int b = 0; b < 3; b++) begin
            read_mem_ir = 1'b1; mem_radrs_ir = 11'(32 + b);
            read_mem_str = 1'b1; mem_radrs_LD = 11'h030;
            tick();
            total++; if (if1 !== 32'h0) $display("FAIL lost_beat%0d got=%h exp=0", b, if1); else passed++;
            total++; if (sd1 !== 32'h1234_5678) $display("FAIL new_beat got=%h exp=12345678", sd1); else passed++;
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_clear_release();
        test_loader();
        test_store_load();
        test_collision();
        test_load_err();
        test_random();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
